// File: rtl/conv_patch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv_patch_sequencer
// Function : 3x3 window sweep over an image memory; tap addressing, latency-
//            timed patch load strobe and valid/ready patch hand-off.
// Revision : 1.0
// ============================================================================
module conv_patch_sequencer #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 1,
  parameter int CW      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] pixel_addrs [0:8],
  output logic              load,
  output logic              patch_valid,
  input  logic              patch_ready,
  output logic              patch_last,
  output logic [CW-1:0]     out_row,
  output logic [CW-1:0]     out_col,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_VALID = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CW-1:0]    C_LAST_ROW = CW'(IMG_H - 3);
  localparam logic [CW-1:0]    C_LAST_COL = CW'(IMG_W - 3);
  localparam logic [CNT_W-1:0] C_CNT_END  = CNT_W'(MEM_LAT - 1);

  logic [2:0]        r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [ADDR_W-1:0] r_base, w_base_next;
  logic [CW-1:0]     w_row_next, w_col_next;
  logic              w_at_last;
  logic              w_load_next, w_valid_next, w_last_next, w_busy_next, w_done_next;

  assign w_at_last = (out_row == C_LAST_ROW) && (out_col == C_LAST_COL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_ISSUE;
      S_ISSUE: if (r_cnt == C_CNT_END) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_VALID;
      S_VALID: if (patch_ready) w_state_next = w_at_last ? S_DONE : S_ISSUE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state/window.
  always_comb begin
    w_cnt_next  = r_cnt;
    w_base_next = r_base;
    w_row_next  = out_row;
    w_col_next  = out_col;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cnt_next  = '0;
          w_base_next = '0;
          w_row_next  = '0;
          w_col_next  = '0;
        end
      end
      S_ISSUE: w_cnt_next = r_cnt + CNT_W'(1);
      S_VALID: begin
        if (patch_ready && !w_at_last) begin
          w_cnt_next = '0;
          if (out_col == C_LAST_COL) begin
            // Skip the two right-edge columns that cannot host a window.
            w_col_next  = '0;
            w_row_next  = out_row + CW'(1);
            w_base_next = r_base + ADDR_W'(3);
          end else begin
            w_col_next  = out_col + CW'(1);
            w_base_next = r_base + ADDR_W'(1);
          end
        end
      end
      default: ;
    endcase
    w_load_next  = (w_state_next == S_LOAD);
    w_valid_next = (w_state_next == S_VALID);
    w_last_next  = (w_state_next == S_VALID) && (w_row_next == C_LAST_ROW) &&
                   (w_col_next == C_LAST_COL);
    w_busy_next  = (w_state_next != S_IDLE);
    w_done_next  = (w_state_next == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_base      <= '0;
      out_row     <= '0;
      out_col     <= '0;
      load        <= 1'b0;
      patch_valid <= 1'b0;
      patch_last  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int k = 0; k < 9; k++) pixel_addrs[k] <= '0;
    end else begin
      r_cnt       <= w_cnt_next;
      r_base      <= w_base_next;
      out_row     <= w_row_next;
      out_col     <= w_col_next;
      load        <= w_load_next;
      patch_valid <= w_valid_next;
      patch_last  <= w_last_next;
      busy        <= w_busy_next;
      done        <= w_done_next;
      for (int k = 0; k < 9; k++)
        pixel_addrs[k] <= w_base_next + ADDR_W'((k / 3) * IMG_W + (k % 3));
    end
  end

endmodule
`default_nettype wire
